// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants and digit helpers for the up/down BCD counter.
package bcd_updown_counter_pkg;
  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] v);
    return v <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle for the BCD counter; master drives controls, slave returns count/status.
interface bcd_updown_counter_if #(parameter int DIGITS = 4);
  logic                  E;
  logic                  Up;
  logic                  Load;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   BCD;
  logic                  TC;
  logic                  Wrap;
  logic                  Err;

  modport master (output E, Up, Load, D, input BCD, TC, Wrap, Err);
  modport slave  (input E, Up, Load, D, output BCD, TC, Wrap, Err);
endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit: load with invalid-digit scrub, and wrap-around up/down step gated by the chain.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic               Clock,
  input  logic               Clear,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  input  logic               cin,
  output logic               cout,
  output logic               bad
);
  logic [DIGIT_W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = digit_ok(d) ? d : BCD_MIN;
    end else if (en && cin) begin
      if (up) q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      else    q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) q_q <= BCD_MIN;
    else       q_q <= q_d;
  end

  assign q    = q_q;
  assign cout = cin & (up ? (q_q == BCD_MAX) : (q_q == BCD_MIN));
  assign bad  = load & ~digit_ok(d);
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, terminal count, wrap pulse and sticky load error.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                E,
  input  logic                Up,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] BCD,
  output logic                TC,
  output logic                Wrap,
  output logic                Err
);
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] bad;
  logic              wrap_d, wrap_q;
  logic              err_d, err_q;

  assign carry[0] = E;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bcd_digit u_dig (
      .Clock (Clock),
      .Clear (Clear),
      .en    (E),
      .up    (Up),
      .load  (Load),
      .d     (D[DIGIT_W*k +: DIGIT_W]),
      .q     (BCD[DIGIT_W*k +: DIGIT_W]),
      .cin   (carry[k]),
      .cout  (carry[k+1]),
      .bad   (bad[k])
    );
  end

  // Carry out of the top digit means every digit sits at its terminal value.
  assign TC = carry[DIGITS] & ~Load;

  always_comb begin
    wrap_d = TC;
    err_d  = err_q | (|bad);
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Wrap = wrap_q;
  assign Err  = err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed + randomized check of bcd_updown_counter against an integer-valued reference model.
module tb_bcd_updown_counter;
  localparam int DIGITS = 4;
  localparam int MAXV   = 9999;

  logic Clock, Clear;
  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .E     (bus.E),
    .Up    (bus.Up),
    .Load  (bus.Load),
    .D     (bus.D),
    .BCD   (bus.BCD),
    .TC    (bus.TC),
    .Wrap  (bus.Wrap),
    .Err   (bus.Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: count held as a plain integer 0..9999.
  int m_val;
  bit m_wrap, m_err;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit model_tc(input bit e, input bit up, input bit load);
    return e && !load && (up ? (m_val == MAXV) : (m_val == 0));
  endfunction

  task automatic model_edge(input bit e, input bit up, input bit load, input logic [15:0] d);
    int nv, w;
    logic [3:0] dg;
    if (load) begin
      nv = 0; w = 1;
      for (int k = 0; k < DIGITS; k++) begin
        dg = d[4*k +: 4];
        if (dg > 4'd9) begin
          dg = 4'd0;
          m_err = 1'b1;
        end
        nv = nv + int'(dg) * w;
        w = w * 10;
      end
      m_val = nv;
      m_wrap = 1'b0;
    end else if (e) begin
      if (up) begin
        m_wrap = (m_val == MAXV);
        m_val = (m_val + 1) % (MAXV + 1);
      end else begin
        m_wrap = (m_val == 0);
        m_val = (m_val + MAXV) % (MAXV + 1);
      end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".bcd"},  bus.BCD, to_bcd(m_val));
    chk({tag, ".wrap"}, {15'd0, bus.Wrap}, {15'd0, m_wrap});
    chk({tag, ".err"},  {15'd0, bus.Err}, {15'd0, m_err});
  endtask

  // Drive one cycle's inputs (just after an edge), check TC, clock it, check registered state.
  task automatic step(input string tag, input bit e, input bit up, input bit load, input logic [15:0] d);
    bus.E = e; bus.Up = up; bus.Load = load; bus.D = d;
    #1;
    chk({tag, ".tc"}, {15'd0, bus.TC}, {15'd0, model_tc(e, up, load)});
    @(posedge Clock);
    model_edge(e, up, load, d);
    #1;
    check_state(tag);
  endtask

  task automatic do_clear(input string tag);
    Clear = 1'b1;
    #1;
    m_val = 0; m_wrap = 1'b0; m_err = 1'b0;
    check_state(tag);
    Clear = 1'b0;
  endtask

  logic [15:0] rd;

  initial begin
    Clear = 1'b1;
    bus.E = 1'b0; bus.Up = 1'b0; bus.Load = 1'b0; bus.D = '0;
    m_val = 0; m_wrap = 1'b0; m_err = 1'b0;
    @(posedge Clock); #1;
    check_state("reset");
    Clear = 1'b0;

    // Count up to 0x0473, then asynchronous clear between edges.
    step("ld470", 1'b0, 1'b1, 1'b1, 16'h0470);
    for (int i = 0; i < 3; i++) step("up473", 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("pre_clr.bcd", bus.BCD, 16'h0473);
    do_clear("clr_mid");

    // Up rollover with TC the cycle before.
    step("ld9998", 1'b0, 1'b1, 1'b1, 16'h9998);
    step("up9999", 1'b1, 1'b1, 1'b0, 16'h0000);
    step("up_roll", 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("up_roll.wrap_const", {15'd0, bus.Wrap}, 16'h0001);
    step("after_roll", 1'b0, 1'b1, 1'b0, 16'h0000);

    // Borrow ripple through three digits.
    step("ld1000", 1'b0, 1'b0, 1'b1, 16'h1000);
    step("dn0999", 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("dn0999.const", bus.BCD, 16'h0999);

    // Down rollover.
    step("ld0000", 1'b0, 1'b0, 1'b1, 16'h0000);
    step("dn_roll", 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("dn_roll.const", bus.BCD, 16'h9999);
    step("dn_hold", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Load beats enable, then hold with Up toggling.
    step("ld_en42", 1'b1, 1'b1, 1'b1, 16'h0042);
    for (int i = 0; i < 5; i++) step("hold42", 1'b0, 1'(i & 1), 1'b0, 16'h0000);
    chk("hold42.const", bus.BCD, 16'h0042);

    // Random run with valid load values only (Err must stay 0).
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = 16'h9999;
        1:       rd = 16'h0000;
        default: rd = to_bcd(int'($urandom_range(0, MAXV)));
      endcase
      step("rnd_ok", 1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 7) == 0, rd);
    end

    // Invalid-digit load scrubs digits and sets sticky Err.
    step("ld3A5F", 1'b0, 1'b1, 1'b1, 16'h3A5F);
    chk("ld3A5F.const", bus.BCD, 16'h3050);
    step("ld1234", 1'b0, 1'b1, 1'b1, 16'h1234);
    chk("ld1234.err_const", {15'd0, bus.Err}, 16'h0001);

    // Random run with arbitrary load data.
    for (int i = 0; i < 300; i++) begin
      rd = 16'($urandom);
      step("rnd_any", 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0, rd);
    end

    // Clear during a Load cycle overrides it.
    bus.Load = 1'b1; bus.D = 16'h5555; bus.E = 1'b1;
    do_clear("clr_load");
    bus.Load = 1'b0; bus.E = 1'b0;
    step("post_clr", 1'b1, 1'b1, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
